mem_stream_tx: RTL
==================

# mem_stream_tx

Memory-backed stream transmitter: holds a vector of up to SIZE signed words, loaded through a simple write port, and on a start pulse streams the first len words out over a valid/ready master interface. Full throughput of one beat per clock is sustained under backpressure. The block is the sending end of the valid/ready streams that feed the convolution datapaths. It is used in the test harness and in the system top to drive s_data_in_x / s_data_in_f.

## Interface
- WIDTH, 8, data word width (signed)
- SIZE, 128, memory depth in words
- LOGSIZE, $clog2(SIZE), address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- wr_en  in  1  load-port write strobe; honoured only while busy=0
- wr_addr  in  LOGSIZE  load-port write address
- wr_data  in  WIDTH  load-port write data (signed)
- start  in  1  begin transfer; honoured only while busy=0
- len  in  LOGSIZE+1  word count, sampled with start; values above SIZE are clamped to SIZE
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  WIDTH  output beat data (signed)

## Operation
- Memory: SIZE x WIDTH, single port, synchronous read with 1-cycle latency. A write has priority over a read on the same cycle, and writes are ignored while busy=1. Memory contents are not cleared by reset.
- FSM states:
  - IDLE: busy=0. On start=1 with len≠0, go to STREAM. On start=1 with len=0, go to FIN.
  - STREAM: busy=1. Go to FIN on the cycle the last beat handshakes (m_valid & m_ready with beats_sent = len-1).
  - FIN: busy=0, done=1 for exactly one cycle, then go to IDLE.
- Counters:
  - rd_addr (LOGSIZE) counts reads issued, from 0 up to len-1.
  - beats_sent (LOGSIZE+1) counts handshakes.
  - Both reset to 0 on start.
- Output buffer: 2-entry skid FIFO (head register drives m_data).
  - A read is issued in a cycle only when rd_addr < len and (occupancy + reads in flight) < 2 after accounting for the pop in that cycle.
  - This guarantees no overflow and continuous streaming with m_ready held high.
- Handshake rules:
  - Once m_valid=1, m_valid stays high and m_data is held stable until m_ready=1.
  - m_valid never depends combinationally on m_ready.
- Data order: beat k carries mem[k], k = 0..len-1.
- start while busy=1 is ignored. start in the FIN cycle is ignored.
- wr_en in the same cycle as an accepted start is performed. That write is visible to the transfer.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_data=0. FSM=IDLE, counters=0, FIFO empty.
- Reset asserted mid-transfer aborts the transfer immediately:
  - m_valid drops asynchronously.
  - No done pulse is produced.
  - The block is in IDLE after reset deasserts.
- Start latency: start sampled at edge E0. The read of address 0 is issued in the cycle after E0. m_valid first rises in the third cycle after E0 (E0+3).
- Throughput: with m_ready=1 throughout, beats appear on len consecutive cycles.
- Backpressure: if m_ready drops for N cycles, the stream resumes without a bubble after m_ready returns. The FIFO is full at most 2 cycles after the stall begins.
- Completion: the last handshake occurs at edge Eh. In the following cycle done=1 and busy=0; m_valid=0 in that cycle. The next start is accepted one cycle later, at the first IDLE edge.
- len=0: done is high in the cycle after the start edge; no beats are sent.
- len=SIZE: rd_addr reaches SIZE-1 and does not wrap; no extra read is issued.

## Test plan
- Full-throughput run:
  - Stimulus: load mem[i]=i-64 for i=0..127, start with len=128, m_ready=1.
  - Required: 128 consecutive beats with data -64..63; first beat at E0+3; done one cycle after the last beat.
- Backpressure:
  - Stimulus: len=10; toggle m_ready 1,0,0,1,0,… pseudo-randomly.
  - Required: exactly 10 beats in order; m_data stable while stalled; no duplicated or dropped word.
- Boundaries:
  - len=0: done at E0+1, no m_valid.
  - len=1: single beat mem[0].
  - len=200: clamped to 128 beats.
- Protocol guards:
  - Stimulus: during a transfer, pulse start and wr_en to addr 3 with value 0x7F.
  - Required: the transfer is unaffected; mem[3] is unchanged on a following readback run.
- Reset mid-transfer:
  - Stimulus: assert reset after beat 5 of a len=20 run.
  - Required: m_valid=0 immediately; no done pulse; a new len=4 run afterwards sends mem[0..3].
- Back-to-back:
  - Stimulus: start again in the first IDLE cycle after done, with len=3.
  - Required: beats mem[0..2] with the same 3-cycle latency.

Source files
------------

// File: rtl/mem_stream_tx.sv
// mem_stream_tx: memory-backed valid/ready stream transmitter.
// A loadable SIZE x WIDTH memory is streamed out, len words per start pulse.
`default_nettype none

module mem_stream_tx #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 128,
    parameter int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               start,
    input  logic [LOGSIZE:0]   len,
    output logic               busy,
    output logic               done,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGSIZE:0] ONE_W  = (LOGSIZE + 1)'(1);

    state_t               state;
    state_t               state_nxt;
    logic [LOGSIZE:0]     len_q;
    logic [LOGSIZE:0]     len_clamped;
    logic [LOGSIZE:0]     rd_cnt;
    logic [LOGSIZE:0]     beats_sent;
    logic [WIDTH-1:0]     mem [SIZE];
    logic [WIDTH-1:0]     rdata;
    logic                 rd_pending;
    logic [WIDTH-1:0]     head;
    logic [WIDTH-1:0]     tail;
    logic [1:0]           count;
    logic [2:0]           occ_after_pop;
    logic                 pop;
    logic                 rd_issue;
    logic                 mem_we;
    logic                 start_ok;
    logic                 last_beat;

    assign m_valid     = (count != 2'd0);
    assign m_data      = head;
    assign pop         = m_valid & m_ready;
    assign len_clamped = (len > SIZE_W) ? SIZE_W : len;
    assign start_ok    = start & (state == IDLE);
    assign mem_we      = wr_en & ~busy;
    assign last_beat   = pop & (beats_sent == len_q - ONE_W);

    // Reads in flight count against FIFO space, so the skid buffer can never overflow.
    assign occ_after_pop = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
    assign rd_issue      = (state == STREAM) && (rd_cnt < len_q) && (occ_after_pop < 3'd2);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len_clamped == '0) ? FIN : STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (last_beat) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory contents survive reset; write wins over read on the same cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end else if (rd_issue) begin
            rdata <= mem[rd_cnt[LOGSIZE-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            rd_cnt     <= '0;
            beats_sent <= '0;
            rd_pending <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= 2'd0;
        end else begin
            state      <= state_nxt;
            rd_pending <= rd_issue;
            if (start_ok) begin
                len_q      <= len_clamped;
                rd_cnt     <= '0;
                beats_sent <= '0;
            end else begin
                if (rd_issue) rd_cnt <= rd_cnt + ONE_W;
                if (pop)      beats_sent <= beats_sent + ONE_W;
            end

            // Two-entry skid FIFO: head drives m_data, tail absorbs one stalled read.
            case ({rd_pending, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= rdata;
                    end else begin
                        head <= tail;
                        tail <= rdata;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) head <= rdata;
                    else               tail <= rdata;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
